pipe_multdiv_unit: RTL and testbench

//  Iterative signed multiply/divide unit for the 5-stage pipeline. Replaces the single-cycle mult/div path in the execute stage.

---
 rtl/pipe_multdiv_unit_pkg.sv | 19 +
 rtl/pipe_multdiv_unit_cond_negate.sv | 13 +
 rtl/pipe_multdiv_unit.sv | 166 ++++++++++++++++
 tb/tb_pipe_multdiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// the execute-stage ALU opcodes that select it, and STATUS exception codes.
package pipe_multdiv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // The execute controller decodes these to drive op_div_i.
  localparam logic [4:0]  ALU_OP_MUL  = 5'b00110;
  localparam logic [4:0]  ALU_OP_DIV  = 5'b00111;

  localparam logic [31:0] STATUS_MULT = 32'd1;
  localparam logic [31:0] STATUS_DIV  = 32'd2;

endpackage

// File: rtl/pipe_multdiv_unit_cond_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and the
// final sign fix of the product/quotient.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? -in_i : in_i;

endmodule

// File: rtl/pipe_multdiv_unit.sv
// Iterative signed multiply (radix-2 shift-add) / divide (restoring) unit that
// stalls the front of the pipeline while it iterates, one bit per cycle.
module pipe_multdiv_unit
  import pipe_multdiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic [TAG_W-1:0] dest_tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_req_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] result_tag_o,
  output logic             mult_exception_o,
  output logic             div_exception_o
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 sign_q, op_div_q, div0_q, div_ovf_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  // Multiplier bits (shifting right) in MUL, dividend/quotient (shifting left) in DIV.
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     divisor_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     result_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 valid_q, mexc_q, dexc_q;

  logic                 issue;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH:0]       rem_sh, rem_diff;
  logic [WIDTH-1:0]     rem_d, quo_d;
  logic [2*WIDTH-1:0]   fix_in, fixed;
  logic                 mul_ovf;

  assign issue = start_i & ~flush_i & (state_q == ST_IDLE);

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .neg_i (operand_a_i[WIDTH-1]),
    .in_i  (operand_a_i),
    .out_o (mag_a)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .neg_i (operand_b_i[WIDTH-1]),
    .in_i  (operand_b_i),
    .out_o (mag_b)
  );

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  // Remainder stays below the divisor, so W+1 bits hold the trial subtraction.
  assign rem_sh   = {rem_q, mplier_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, divisor_q};
  assign rem_d    = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
  assign quo_d    = {mplier_q[WIDTH-2:0], ~rem_diff[WIDTH]};

  assign fix_in = op_div_q ? {{WIDTH{1'b0}}, mplier_q} : acc_q;

  cond_negate #(.WIDTH(2*WIDTH)) u_fix (
    .neg_i (sign_q),
    .in_i  (fix_in),
    .out_o (fixed)
  );

  assign mul_ovf = fixed[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){fixed[WIDTH-1]}};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      op_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      div_ovf_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      mexc_q    <= 1'b0;
      dexc_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            cnt_q     <= '0;
            sign_q    <= operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1];
            op_div_q  <= op_div_i;
            div0_q    <= op_div_i & (operand_b_i == '0);
            div_ovf_q <= (operand_a_i == MIN_VAL) & (operand_b_i == '1);
            acc_q     <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, mag_a};
            mplier_q  <= op_div_i ? mag_a : mag_b;
            divisor_q <= mag_b;
            rem_q     <= '0;
            tag_q     <= dest_tag_i;
            mexc_q    <= 1'b0;
            dexc_q    <= 1'b0;
            if (!op_div_i)               state_q <= ST_MUL;
            else if (operand_b_i == '0)  state_q <= ST_DONE;
            else                         state_q <= ST_DIV;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        ST_DIV: begin
          rem_q    <= rem_d;
          mplier_q <= quo_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (!flush_i) begin
            valid_q <= 1'b1;
            if (div0_q) begin
              result_q <= '0;
              dexc_q   <= 1'b1;
            end else if (op_div_q) begin
              result_q <= fixed[WIDTH-1:0];
              dexc_q   <= div_ovf_q;
            end else begin
              result_q <= fixed[WIDTH-1:0];
              mexc_q   <= mul_ovf;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (flush_i) state_q <= ST_IDLE;
    end
  end

  assign busy_o           = (state_q != ST_IDLE);
  assign stall_req_o      = issue | (state_q == ST_MUL) | (state_q == ST_DIV);
  assign result_valid_o   = valid_q;
  assign result_o         = result_q;
  assign result_tag_o     = tag_q;
  assign mult_exception_o = mexc_q;
  assign div_exception_o  = dexc_q;

endmodule

// File: tb/tb_pipe_multdiv_unit.sv
// Scoreboard bench for pipe_multdiv_unit: directed cases plus random ops
// checked against plain signed arithmetic.
module tb_pipe_multdiv_unit;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clock = 1'b0, reset = 1'b1;
  logic          start = 1'b0, op_div = 1'b0, flush = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic [TW-1:0] tag = '0;
  logic          busy, stall_req, result_valid, mexc, dexc;
  logic [W-1:0]  result;
  logic [TW-1:0] result_tag;

  pipe_multdiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .start_i          (start),
    .op_div_i         (op_div),
    .operand_a_i      (a),
    .operand_b_i      (b),
    .dest_tag_i       (tag),
    .flush_i          (flush),
    .busy_o           (busy),
    .stall_req_o      (stall_req),
    .result_valid_o   (result_valid),
    .result_o         (result),
    .result_tag_o     (result_tag),
    .mult_exception_o (mexc),
    .div_exception_o  (dexc)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          mexc;
    logic          dexc;
    int            cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         me;
  int           n_pass = 0, n_total = 0;
  int           stall_cnt = 0;
  logic [W-1:0] last_res = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic exp_t model(bit op, logic [W-1:0] x, logic [W-1:0] y,
                                 logic [TW-1:0] t, int c);
    exp_t   e;
    longint sx, sy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.tag = t; e.mexc = 1'b0; e.dexc = 1'b0; e.cyc = c + W + 2;
    if (!op) begin
      p = sx * sy;
      e.res  = p[W-1:0];
      e.mexc = (p != longint'($signed(e.res)));
    end else if (y == '0) begin
      e.res = '0; e.dexc = 1'b1; e.cyc = c + 2;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.res = x; e.dexc = 1'b1;
    end else begin
      p = sx / sy;
      e.res = p[W-1:0];
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return W'($urandom_range(0, 100)) - 32'd50;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0000_0000;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  // Called at posedge+1 with the DUT idle; start is seen at the next edge.
  task automatic issue(input bit op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [TW-1:0] t, input bit track);
    a = x; b = y; op_div = op; tag = t; start = 1'b1;
    if (track) sb.push_back(model(op, x, y, t, cyc));
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (stall_req) stall_cnt++;
    if (result_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        me = sb.pop_front();
        chk("result",   result,     me.res);
        chk("tag",      result_tag, me.tag);
        chk("mult_exc", mexc,       me.mexc);
        chk("div_exc",  dexc,       me.dexc);
        chk("latency",  cyc,        me.cyc);
        last_res = me.res;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int s0;
    step(2);
    chk("rst_busy",  busy,         0);
    chk("rst_stall", stall_req,    0);
    chk("rst_valid", result_valid, 0);
    chk("rst_res",   result,       0);
    chk("rst_tag",   result_tag,   0);
    chk("rst_mexc",  mexc,         0);
    chk("rst_dexc",  dexc,         0);
    reset = 1'b0;
    step(1);

    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b1);
    wait_done();

    s0 = stall_cnt;
    issue(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd3, 1'b1);
    wait_done();
    chk("stall_cycles", stall_cnt - s0, 33);

    issue(1'b1, 32'hFFFF_FFEC, 32'd3, 5'd1, 1'b1);
    wait_done();
    step(3);
    chk("result_hold", result, last_res);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 1'b1);
    wait_done();
    issue(1'b1, 32'd5, 32'd0, 5'd4, 1'b1);
    wait_done();

    // Flush ten cycles into a multiply, then re-issue at once.
    issue(1'b0, 32'd5, 32'd7, 5'd5, 1'b0);
    step(9);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_busy",  busy,      0);
    chk("flush_stall", stall_req, 0);
    issue(1'b0, 32'd2, 32'd3, 5'd6, 1'b1);
    wait_done();

    // Start while busy is ignored.
    issue(1'b1, 32'd1000, 32'd7, 5'd7, 1'b1);
    step(4);
    a = 32'd9; b = 32'd9; op_div = 1'b0; tag = 5'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of a divide.
    issue(1'b1, 32'd12345, 32'hFFFF_FFEF, 5'd8, 1'b1);
    step(9);
    reset = 1'b1;
    #1;
    chk("midrst_busy",  busy,         0);
    chk("midrst_stall", stall_req,    0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_res",   result,       0);
    chk("midrst_tag",   result_tag,   0);
    sb.delete();
    step(1);
    reset = 1'b0;
    step(40);

    // start and flush together: no issue.
    a = 32'd3; b = 32'd4; op_div = 1'b0; tag = 5'd11; start = 1'b1; flush = 1'b1;
    step(1);
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", busy, 0);
    step(40);

    // Flush landing on the DONE cycle suppresses the result.
    issue(1'b0, 32'd11, 32'd13, 5'd12, 1'b0);
    step(W);
    chk("done_busy", busy, 1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("doneflush_busy", busy, 0);
    step(5);
    chk("doneflush_res", result, 0);

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), pick(), pick(), TW'($urandom_range(0, 31)), 1'b1);
      wait_done();
    end

    step(2);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
